// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch stage
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - single-outstanding instruction-memory req/ack bus
interface fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch buffer of {instr, pcp4} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_count   = r_count;
  // Empty buffer presents a NOP with zero PC+4 to IF/ID.
  assign o_head    = (r_count == '0) ? '0 : r_mem[r_rd];

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage; contents are masked by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush && w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, next-address select, imem handshake and fetch buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  fetch_if.master     imem,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcp4
);
  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   PC_INIT = RESET_PC & ~32'h3;

  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_addr;
  logic          r_req;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_has_space;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_level;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Branch resolves in EX and is older than a jump in ID, so it wins.
  assign w_redirect   = branch_taken | jump;
  assign w_target     = (branch_taken ? branch_addr : jump_addr) & ~32'h3;
  // Acks are only meaningful while our request is on the bus.
  assign w_ack        = r_req & imem.ack;
  assign w_pop        = ifid_valid & ~stall & ~w_redirect;
  assign w_push       = (r_state == S_WAIT) & w_ack & ~w_redirect;
  assign w_push_entry = '{instr: imem.data, pcp4: r_req_addr + 32'd4};
  assign w_level      = w_count + CW'(w_push) - CW'(w_pop);
  assign w_has_space  = (w_level < DEPTH_C);

  assign imem.req   = r_req;
  assign imem.addr  = r_req_addr;
  assign ifid_valid = (w_count != '0);
  assign ifid_instr = w_head.instr;
  assign ifid_pcp4  = w_head.pcp4;

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head),
    .o_full  (w_full)
  );

  // Fetch FSM: issues requests, holds them until ack, drains a stale one after redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_INIT;
      r_req_addr <= '0;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            r_req_addr <= w_target;
            r_pc       <= w_target + 32'd4;
            r_req      <= 1'b1;
            r_state    <= S_WAIT;
          end else if (!w_full || w_pop) begin
            r_req_addr <= r_pc;
            r_pc       <= r_pc + 32'd4;
            r_req      <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redirect) begin
            if (w_ack) begin
              // Returned word belongs to the old path; go straight to the target.
              r_req_addr <= w_target;
              r_pc       <= w_target + 32'd4;
            end else begin
              // Request must stay stable until acked, so drain it first.
              r_pc    <= w_target;
              r_state <= S_DISCARD;
            end
          end else if (w_ack) begin
            if (w_has_space) begin
              r_req_addr <= r_pc;
              r_pc       <= r_pc + 32'd4;
            end else begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (w_ack) begin
            // Buffer was flushed on entry, so there is always room to issue.
            r_req_addr <= w_redirect ? w_target : r_pc;
            r_pc       <= (w_redirect ? w_target : r_pc) + 32'd4;
            r_state    <= S_WAIT;
          end else if (w_redirect) begin
            r_pc <= w_target;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcp4;

  int          mem_lat = 0;
  logic        force_ack = 1'b0;
  int          mem_cnt = 0;

  int          n_checks = 0;
  int          n_pass = 0;

  fetch_if imem_if ();

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .imem         (imem_if),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pcp4    (ifid_pcp4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h2402_0000;
  endfunction

  // Instruction memory: acks after mem_lat cycles of a held request.
  always_comb begin
    imem_if.ack  = force_ack | (imem_if.req && (mem_cnt >= mem_lat));
    imem_if.data = imem_if.ack ? instr_at(imem_if.addr) : 32'h0;
  end

  always @(posedge clk) begin
    if (rst || imem_if.ack || !imem_if.req) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    force_ack = 1'b0; mem_lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_if.req); else n_pass++;
    n_checks++; if (imem_if.addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_if.addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", ifid_instr); else n_pass++;
    n_checks++; if (ifid_pcp4 !== 32'h0) $display("FAIL reset_pcp4 got %h want 0", ifid_pcp4); else n_pass++;
  endtask

  task automatic test_first_fetch();
    do_reset();
    @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0) $display("FAIL first_req got %b/%h want 1/0", imem_if.req, imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifid_valid !== 1'b1) $display("FAIL first_valid got %b want 1", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== 32'h2008_0005) $display("FAIL first_instr got %h want 20080005", ifid_instr); else n_pass++;
    n_checks++; if (ifid_pcp4 !== 32'h4) $display("FAIL first_pcp4 got %h want 4", ifid_pcp4); else n_pass++;
  endtask

  task automatic test_stall_fill();
    do_reset();
    stall = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b0) $display("FAIL fill_req got %b want 0", imem_if.req); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pcp4 !== 32'h4) $display("FAIL fill_head got %b/%h want 1/4", ifid_valid, ifid_pcp4); else n_pass++;
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (ifid_instr !== instr_at(32'h4) || ifid_pcp4 !== 32'h8) $display("FAIL fill_pop1 got %h/%h want %h/8", ifid_instr, ifid_pcp4, instr_at(32'h4)); else n_pass++;
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h8) $display("FAIL fill_next_req got %b/%h want 1/8", imem_if.req, imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pcp4 !== 32'hC) $display("FAIL fill_pop2 got %b/%h want 1/c", ifid_valid, ifid_pcp4); else n_pass++;
  endtask

  task automatic test_branch_flush();
    do_reset();
    stall = 1'b1;
    repeat (4) @(negedge clk);
    branch_taken = 1'b1; branch_addr = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0; branch_addr = 32'h0; stall = 1'b0;
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL flush_valid got %b/%h want 0/0", ifid_valid, ifid_instr); else n_pass++;
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h40) $display("FAIL flush_addr got %b/%h want 1/40", imem_if.req, imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pcp4 !== 32'h44 || ifid_instr !== instr_at(32'h40)) $display("FAIL flush_first got %b/%h/%h want 1/44/%h", ifid_valid, ifid_pcp4, ifid_instr, instr_at(32'h40)); else n_pass++;
  endtask

  task automatic test_slow_redirect();
    logic found;
    do_reset();
    mem_lat = 3;
    repeat (2) @(negedge clk);
    jump = 1'b1; jump_addr = 32'h100;
    @(negedge clk);
    jump = 1'b0; jump_addr = 32'h0;
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0) $display("FAIL discard_hold1 got %b/%h want 1/0", imem_if.req, imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0) $display("FAIL discard_hold2 got %b/%h want 1/0", imem_if.req, imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (imem_if.addr !== 32'h100 || ifid_valid !== 1'b0) $display("FAIL discard_target got %h/%b want 100/0", imem_if.addr, ifid_valid); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifid_valid) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1 || ifid_pcp4 !== 32'h104) $display("FAIL discard_first got %b/%h want 1/104", found, ifid_pcp4); else n_pass++;
    mem_lat = 0;
  endtask

  task automatic test_simul_redirect();
    do_reset();
    repeat (3) @(negedge clk);
    branch_taken = 1'b1; branch_addr = 32'h80;
    jump = 1'b1; jump_addr = 32'h200;
    @(negedge clk);
    branch_taken = 1'b0; jump = 1'b0;
    n_checks++; if (imem_if.addr !== 32'h80) $display("FAIL prio_addr got %h want 80", imem_if.addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pcp4 !== 32'h84) $display("FAIL prio_first got %b/%h want 1/84", ifid_valid, ifid_pcp4); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic found;
    do_reset();
    mem_lat = 3;
    @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b1) $display("FAIL midrst_req got %b want 1", imem_if.req); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_if.req !== 1'b0 || imem_if.addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pcp4 !== 32'h0) $display("FAIL midrst_outs got %b/%h/%b/%h want 0/0/0/0", imem_if.req, imem_if.addr, ifid_valid, ifid_pcp4); else n_pass++;
    rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL midrst_stray got %b/%h want 0/0", ifid_valid, ifid_instr); else n_pass++;
    n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0) $display("FAIL midrst_restart got %b/%h want 1/0", imem_if.req, imem_if.addr); else n_pass++;
    mem_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifid_valid) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1 || ifid_pcp4 !== 32'h4 || ifid_instr !== 32'h2008_0005) $display("FAIL midrst_first got %b/%h/%h want 1/4/20080005", found, ifid_pcp4, ifid_instr); else n_pass++;
  endtask

  // Program-order model: after a redirect to T the stream is T, T+4, ...
  task automatic test_random();
    logic [31:0] exp_pc, p_addr, tgt, other;
    logic        just_redir, p_req, p_ack;
    int          delivered, r;
    do_reset();
    exp_pc = 32'h0; just_redir = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = '0; delivered = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (just_redir) begin
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL rnd_redir_valid cyc %0d got %b want 0", c, ifid_valid); else n_pass++;
      end
      if (ifid_valid) begin
        n_checks++; if (ifid_instr !== instr_at(exp_pc) || ifid_pcp4 !== exp_pc + 32'd4) $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", c, ifid_instr, ifid_pcp4, instr_at(exp_pc), exp_pc + 32'd4); else n_pass++;
      end
      if (p_req && !p_ack) begin
        n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== p_addr) $display("FAIL rnd_hold cyc %0d got %b/%h want 1/%h", c, imem_if.req, imem_if.addr, p_addr); else n_pass++;
      end
      stall = ($urandom_range(0, 2) == 0);
      mem_lat = $urandom_range(0, 3);
      branch_taken = 1'b0; jump = 1'b0; just_redir = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 1023);
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'(r) << 2;
        r = $urandom_range(0, 1023);
        other = 32'(r) << 2;
        if ($urandom_range(0, 1) == 1) begin
          branch_taken = 1'b1; branch_addr = tgt;
          jump_addr = other; jump = ($urandom_range(0, 1) == 1);
        end else begin
          jump = 1'b1; jump_addr = tgt; branch_addr = other;
        end
        exp_pc = tgt; just_redir = 1'b1;
      end else if (ifid_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      #1;
      p_req = imem_if.req; p_ack = imem_if.ack; p_addr = imem_if.addr;
    end
    @(negedge clk);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0; mem_lat = 0;
    n_checks++; if (delivered < 50) $display("FAIL rnd_throughput got %0d want >=50", delivered); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_fill();
    test_branch_flush();
    test_slow_redirect();
    test_simul_redirect();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
